gray_mem_arbiter: RTL and testbench



---
 rtl/lbp_pkg.sv | 27 ++
 rtl/gray_mem_arbiter_if.sv | 44 ++++
 rtl/gray_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_gray_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP image pipeline: image geometry, pixel
// width and the gray-memory arbiter state encoding.
package lbp_pkg;

   // 128x128 gray image, one byte per pixel.
   localparam int IMG_ADDR_W = 14;
   localparam int PIX_W      = 8;

   // Arbiter state encoding, shared with anything that decodes arbiter state.
   localparam logic [1:0] ARB_IDLE = 2'd0;
   localparam logic [1:0] ARB_OWN0 = 2'd1;
   localparam logic [1:0] ARB_OWN1 = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = ARB_IDLE,
      ST_OWN0 = ARB_OWN0,
      ST_OWN1 = ARB_OWN1
   } arb_state_e;

   // Width of a counter that must reach max_hold; never narrower than 1 bit.
   function automatic int hold_cnt_width(input int max_hold);
      int w;
      w = $clog2(max_hold + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/gray_mem_arbiter_if.sv
// Bundle of the gray-memory read port plus both requester channels.
// The slave modport is the arbiter's view; master is everything around it
// (the two requesters and the gray memory).
interface gray_mem_arbiter_if import lbp_pkg::*; #(
   parameter int ADDR_W = IMG_ADDR_W,
   parameter int DATA_W = PIX_W
);

   // gray memory side
   logic              gray_ready;
   logic              gray_req;
   logic [ADDR_W-1:0] gray_addr;
   logic [DATA_W-1:0] gray_data;

   // requester 0: LBP engine
   logic              rq0_req;
   logic [ADDR_W-1:0] rq0_addr;
   logic              rq0_gnt;

   // requester 1: host/loader readback
   logic              rq1_req;
   logic [ADDR_W-1:0] rq1_addr;
   logic              rq1_gnt;

   // shared return path and status
   logic [DATA_W-1:0] rd_data;
   logic              owner;
   logic              busy;

   modport slave (
      input  gray_ready, gray_data,
      input  rq0_req, rq0_addr, rq1_req, rq1_addr,
      output gray_req, gray_addr,
      output rq0_gnt, rq1_gnt, rd_data, owner, busy
   );

   modport master (
      output gray_ready, gray_data,
      output rq0_req, rq0_addr, rq1_req, rq1_addr,
      input  gray_req, gray_addr,
      input  rq0_gnt, rq1_gnt, rd_data, owner, busy
   );

endinterface

// File: rtl/gray_mem_arbiter.sv
// Two-way arbiter for the single gray-image memory read port.
// Requester 0 is the LBP engine, requester 1 the host/loader readback.
// Ownership is registered and locked to the owner's request; ties go
// round-robin against the last owner; a hold counter lets a waiting
// requester preempt after MAX_HOLD cycles (MAX_HOLD=0 disables that).
// Nothing is granted while gray_ready is low.
module gray_mem_arbiter import lbp_pkg::*; #(
   parameter int ADDR_W   = IMG_ADDR_W,
   parameter int DATA_W   = PIX_W,
   parameter int MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              reset,
   gray_mem_arbiter_if.slave bus
);

   localparam int              CNT_W      = hold_cnt_width(MAX_HOLD);
   localparam bit              PREEMPT_EN = (MAX_HOLD != 0);
   // Counter value at which a waiting requester takes over.
   localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   arb_state_e        state_q, state_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;

   // View of the request lines relative to the current owner.
   logic              cur_idx;
   logic              own_req;
   logic              oth_req;

   // Award decision shared by all branches of the next-state logic.
   logic              award_vld;
   logic              award_idx;

   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] rd_data;

   // Resolve which request belongs to the owner and which to the other side.
   always_comb begin
      cur_idx = (state_q == ST_OWN1);
      own_req = cur_idx ? bus.rq1_req : bus.rq0_req;
      oth_req = cur_idx ? bus.rq0_req : bus.rq1_req;
   end

   // Next-state, last-owner and hold-counter logic.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      award_vld  = 1'b0;
      award_idx  = 1'b0;

      if (!bus.gray_ready) begin
         // Memory not valid: drop any grant but remember who was last.
         state_d    = ST_IDLE;
         hold_cnt_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               hold_cnt_d = '0;
               if (bus.rq0_req && bus.rq1_req) begin
                  // Tie: whoever was not served last wins.
                  award_vld = 1'b1;
                  award_idx = ~last_q;
               end else if (bus.rq0_req) begin
                  award_vld = 1'b1;
                  award_idx = 1'b0;
               end else if (bus.rq1_req) begin
                  award_vld = 1'b1;
                  award_idx = 1'b1;
               end
            end

            ST_OWN0, ST_OWN1: begin
               if (!own_req) begin
                  // Owner released: hand straight over, or go idle.
                  if (oth_req) begin
                     award_vld = 1'b1;
                     award_idx = ~cur_idx;
                  end else begin
                     state_d    = ST_IDLE;
                     hold_cnt_d = '0;
                  end
               end else if (oth_req) begin
                  // Other side is waiting: count tenure, preempt at the limit.
                  if (PREEMPT_EN && (hold_cnt_q == HOLD_LIMIT)) begin
                     award_vld = 1'b1;
                     award_idx = ~cur_idx;
                  end else if (hold_cnt_q != HOLD_LIMIT) begin
                     hold_cnt_d = hold_cnt_q + CNT_W'(1);
                  end
               end else begin
                  // Nobody waiting: tenure is not charged.
                  hold_cnt_d = '0;
               end
            end

            default: begin
               state_d    = ST_IDLE;
               hold_cnt_d = '0;
            end
         endcase
      end

      // Every entry into an OWN state restarts the tenure and records the owner.
      if (award_vld) begin
         state_d    = award_idx ? ST_OWN1 : ST_OWN0;
         last_d     = award_idx;
         hold_cnt_d = '0;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its _d input regardless of block order.
      if (reset) begin
         state_q    <= ST_IDLE;
         last_q     <= 1'b1;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // Address mux: owner's address while granted, zero when idle.
   always_comb begin
      addr_mux = '0;
      unique case (state_q)
         ST_OWN0: addr_mux = bus.rq0_addr;
         ST_OWN1: addr_mux = bus.rq1_addr;
         default: addr_mux = '0;
      endcase
   end

   assign rd_data = bus.gray_data;

   // Outputs decoded from state; gray_req also needs the owner's live request.
   always_comb begin
      bus.rq0_gnt   = (state_q == ST_OWN0);
      bus.rq1_gnt   = (state_q == ST_OWN1);
      bus.busy      = (state_q != ST_IDLE);
      bus.owner     = last_q;
      bus.gray_req  = ((state_q == ST_OWN0) && bus.rq0_req) ||
                      ((state_q == ST_OWN1) && bus.rq1_req);
      bus.gray_addr = addr_mux;
      bus.rd_data   = rd_data;
   end

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Self-checking bench for gray_mem_arbiter: directed scenarios followed by
// random traffic. A behavioural model predicts each cycle's outputs into a
// queue; an independent monitor pops and compares on the falling edge.
module tb_gray_mem_arbiter;
   import lbp_pkg::*;

   localparam int AW = IMG_ADDR_W;
   localparam int DW = PIX_W;
   localparam int MH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   gray_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   gray_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Gray memory: combinational read.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign bus.gray_data = mem[bus.gray_addr];

   typedef struct packed {
      logic [31:0]   cyc;
      logic          gnt0;
      logic          gnt1;
      logic          busy;
      logic          owner;
      logic          req;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   // Behavioural model: who owns the port, who was served last, and how many
   // cycles the other side has been kept waiting in the current tenure.
   int m_cur   = -1;
   int m_last  = 1;
   int m_wait  = 0;
   bit m_known = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic award(input int n);
      m_cur  = n;
      m_last = n;
      m_wait = 0;
   endtask

   task automatic model_step(input bit r, input bit rdy, input bit q0, input bit q1);
      bit q [2];
      int me;
      int other;
      q[0] = q0;
      q[1] = q1;
      if (r) begin
         m_cur = -1; m_last = 1; m_wait = 0; m_known = 1'b1;
         return;
      end
      if (!rdy) begin
         m_cur = -1; m_wait = 0;
         return;
      end
      if (m_cur < 0) begin
         if (q0 && q1) award(1 - m_last);
         else if (q0)  award(0);
         else if (q1)  award(1);
      end else begin
         me    = m_cur;
         other = 1 - m_cur;
         if (!q[me]) begin
            if (q[other]) award(other);
            else begin m_cur = -1; m_wait = 0; end
         end else if (q[other]) begin
            m_wait++;
            if (MH != 0 && m_wait >= MH) award(other);
         end else begin
            m_wait = 0;
         end
      end
   endtask

   // One clock cycle: apply inputs just after the edge, predict this cycle's
   // outputs, then advance the model to what the next edge will produce.
   task automatic dc(input bit r, input bit rdy, input bit q0, input int a0,
                     input bit q1, input int a1);
      exp_t e;
      logic [AW-1:0] a0v, a1v;
      @(posedge clk);
      #1;
      a0v = a0[AW-1:0];
      a1v = a1[AW-1:0];
      reset          = r;
      bus.gray_ready = rdy;
      bus.rq0_req    = q0;
      bus.rq0_addr   = a0v;
      bus.rq1_req    = q1;
      bus.rq1_addr   = a1v;
      cyc++;
      if (m_known) begin
         e.cyc   = cyc;
         e.gnt0  = (m_cur == 0);
         e.gnt1  = (m_cur == 1);
         e.busy  = (m_cur >= 0);
         e.owner = (m_last == 1);
         e.req   = (m_cur == 0) ? q0 : (m_cur == 1) ? q1 : 1'b0;
         e.addr  = (m_cur == 0) ? a0v : (m_cur == 1) ? a1v : '0;
         e.data  = mem[e.addr];
         exp_q.push_back(e);
      end
      model_step(r, rdy, q0, q1);
   endtask

   // Monitor: compares the DUT against the oldest prediction each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("c%0d rq0_gnt", e.cyc),   bus.rq0_gnt,   e.gnt0);
            check($sformatf("c%0d rq1_gnt", e.cyc),   bus.rq1_gnt,   e.gnt1);
            check($sformatf("c%0d busy", e.cyc),      bus.busy,      e.busy);
            check($sformatf("c%0d owner", e.cyc),     bus.owner,     e.owner);
            check($sformatf("c%0d gray_req", e.cyc),  bus.gray_req,  e.req);
            check($sformatf("c%0d gray_addr", e.cyc), bus.gray_addr, e.addr);
            check($sformatf("c%0d rd_data", e.cyc),   bus.rd_data,   e.data);
         end
      end
   end

   // Stimulus and directed spot checks.
   initial begin
      bit q0, q1, rdy, r;
      int a0, a1;
      int drain;

      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
      reset = 1'b1; bus.gray_ready = 1'b0;
      bus.rq0_req = 1'b0; bus.rq0_addr = '0;
      bus.rq1_req = 1'b0; bus.rq1_addr = '0;

      // Reset state
      dc(1, 1, 0, 0, 0, 0);
      dc(1, 1, 0, 0, 0, 0);
      #1;
      check("rst busy",  bus.busy,    1'b0);
      check("rst owner", bus.owner,   1'b1);
      check("rst gnt0",  bus.rq0_gnt, 1'b0);
      check("rst gnt1",  bus.rq1_gnt, 1'b0);
      check("rst req",   bus.gray_req, 1'b0);

      // Single requester, one-cycle grant latency
      dc(0, 1, 1, 'h0081, 0, 0);
      #1 check("t1 latency gnt0", bus.rq0_gnt, 1'b0);
      dc(0, 1, 1, 'h0081, 0, 0);
      #1;
      check("t1 gnt0",  bus.rq0_gnt,   1'b1);
      check("t1 addr",  bus.gray_addr, 32'h0081);
      check("t1 data",  bus.rd_data,   mem['h0081]);
      check("t1 owner", bus.owner,     1'b0);
      dc(0, 1, 0, 0, 0, 0);
      dc(0, 1, 0, 0, 0, 0);

      // Simultaneous requests: rq0 first, gapless handover to rq1
      dc(1, 1, 0, 0, 0, 0);
      dc(0, 1, 1, 'h10, 1, 'h20);
      for (int i = 0; i < 3; i++) begin
         dc(0, 1, 1, 'h10, 1, 'h20);
         #1 check("t2 gnt0", bus.rq0_gnt, 1'b1);
      end
      dc(0, 1, 0, 'h10, 1, 'h20);
      #1 check("t2 release req", bus.gray_req, 1'b0);
      dc(0, 1, 0, 'h10, 1, 'h20);
      #1;
      check("t2 handover gnt1", bus.rq1_gnt,   1'b1);
      check("t2 owner",         bus.owner,     1'b1);
      check("t2 addr",          bus.gray_addr, 32'h20);
      dc(0, 1, 0, 0, 0, 0);
      dc(0, 1, 0, 0, 0, 0);

      // Preemption after MAX_HOLD waiting cycles, then rq0 regains the port
      dc(1, 1, 0, 0, 0, 0);
      dc(0, 1, 1, 'h1234, 0, 0);
      dc(0, 1, 1, 'h1234, 0, 0);
      for (int d = 1; d <= 4; d++) begin
         dc(0, 1, 1, 'h1234, 1, 'h0777);
         #1 check($sformatf("t3 hold gnt0 d%0d", d), bus.rq0_gnt, 1'b1);
      end
      dc(0, 1, 1, 'h1234, 1, 'h0777);
      #1;
      check("t3 preempt gnt1", bus.rq1_gnt,   1'b1);
      check("t3 preempt addr", bus.gray_addr, 32'h0777);
      dc(0, 1, 1, 'h1234, 1, 'h0777);
      dc(0, 1, 1, 'h1234, 0, 'h0777);
      dc(0, 1, 1, 'h1234, 0, 'h0777);
      #1;
      check("t3 regain gnt0", bus.rq0_gnt,   1'b1);
      check("t3 regain addr", bus.gray_addr, 32'h1234);
      dc(0, 1, 0, 0, 0, 0);
      dc(0, 1, 0, 0, 0, 0);

      // Lone requester is never preempted
      dc(1, 1, 0, 0, 0, 0);
      dc(0, 1, 1, 'h0042, 0, 0);
      for (int i = 0; i < 20; i++) begin
         dc(0, 1, 1, 'h0042, 0, 0);
         #1 check($sformatf("t4 lone gnt0 %0d", i), bus.rq0_gnt, 1'b1);
      end
      dc(0, 1, 0, 0, 0, 0);

      // gray_ready drop during OWN1, then tie goes to rq0 (last=1)
      dc(1, 1, 0, 0, 0, 0);
      dc(0, 1, 0, 0, 1, 'h0300);
      dc(0, 1, 0, 0, 1, 'h0300);
      dc(0, 0, 0, 0, 1, 'h0300);
      #1 check("t5 own1 before drop", bus.rq1_gnt, 1'b1);
      dc(0, 0, 0, 0, 1, 'h0300);
      #1;
      check("t5 notready busy", bus.busy,     1'b0);
      check("t5 notready req",  bus.gray_req, 1'b0);
      check("t5 notready gnt1", bus.rq1_gnt,  1'b0);
      dc(0, 1, 1, 'h0011, 1, 'h0300);
      #1 check("t5 ready back idle", bus.busy, 1'b0);
      dc(0, 1, 1, 'h0011, 1, 'h0300);
      #1 check("t5 tie gnt0", bus.rq0_gnt, 1'b1);
      dc(0, 1, 0, 0, 0, 0);

      // Reset mid-grant; pending rq1 re-granted one cycle after release
      dc(1, 1, 0, 0, 0, 0);
      dc(0, 1, 0, 0, 1, 'h0555);
      dc(0, 1, 0, 0, 1, 'h0555);
      #1 check("t6 gnt1 before reset", bus.rq1_gnt, 1'b1);
      dc(1, 1, 0, 0, 1, 'h0555);
      dc(0, 1, 0, 0, 1, 'h0555);
      #1;
      check("t6 reset gnt1",  bus.rq1_gnt, 1'b0);
      check("t6 reset gnt0",  bus.rq0_gnt, 1'b0);
      check("t6 reset busy",  bus.busy,    1'b0);
      check("t6 reset owner", bus.owner,   1'b1);
      dc(0, 1, 0, 0, 1, 'h0555);
      #1 check("t6 regrant gnt1", bus.rq1_gnt, 1'b1);

      // Random traffic: requests held for random spans, addresses wander
      q0 = 1'b0; q1 = 1'b0;
      a0 = int'($urandom_range(0, (1 << AW) - 1));
      a1 = int'($urandom_range(0, (1 << AW) - 1));
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 4) == 0) q0 = ~q0;
         if ($urandom_range(0, 4) == 0) q1 = ~q1;
         if ($urandom_range(0, 7) == 0) a0 = int'($urandom_range(0, (1 << AW) - 1));
         if ($urandom_range(0, 7) == 0) a1 = int'($urandom_range(0, (1 << AW) - 1));
         rdy = ($urandom_range(0, 19) != 0);
         r   = ($urandom_range(0, 99) == 0);
         dc(r, rdy, q0, a0, q1, a1);
      end
      dc(0, 1, 0, 0, 0, 0);

      // Let the monitor consume the last predictions, bounded.
      drain = 0;
      while (exp_q.size() > 0 && drain < 8) begin
         @(negedge clk);
         #1;
         drain++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
